conv3_window_mac: RTL and testbench

- Consumer at the read end of the pool2 output line buffer.
- Takes the windowed tap stream: one `ready` strobe, then `weight_num` consecutive beats of `channel_num` pixels with the matching weight word per beat.
- Multiply-accumulates each beat into `out_num` parallel accumulators.
- Emits one saturated fixed-point pixel per output filter per window.

---
 rtl/conv3_window_mac_pkg.sv | 22 ++
 rtl/conv3_mac_lane.sv | 87 ++++++++
 rtl/conv3_window_mac.sv | 117 +++++++++++
 tb/tb_conv3_window_mac.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/conv3_window_mac_pkg.sv
// Shared Q-format constants, saturation bounds, FSM states and the weight-word layout
// used by the windowed MAC and the line buffer's weight ROM.
package conv3_window_mac_pkg;

   localparam int unsigned QBits     = 16;
   localparam int unsigned QFracBits = 8;

   localparam int SatMax = (2 ** (QBits - 1)) - 1;
   localparam int SatMin = -(2 ** (QBits - 1));

   typedef enum logic [0:0] {
      StIdle,
      StAcc
   } win_state_e;

   // Weight word k for filter o, channel c; must match the buffer's ROM ordering.
   function automatic int unsigned weight_idx(input int unsigned o, input int unsigned c,
                                              input int unsigned n_ch);
      return o * n_ch + c;
   endfunction

endpackage

// File: rtl/conv3_mac_lane.sv
// One output filter: channel dot product per beat, window accumulator, and the
// shift / saturate / optional ReLU stage that produces the registered result pixel.
module conv3_mac_lane
   import conv3_window_mac_pkg::*;
#(
   parameter int unsigned bits        = QBits,
   parameter int unsigned channel_num = 8,
   parameter int unsigned frac_bits   = QFracBits,
   parameter int unsigned acc_bits    = 40,
   parameter bit          relu_en     = 1'b1
) (
   input  logic                        clk_in,
   input  logic                        rst_n,
   input  logic                        load_i,
   input  logic                        acc_en_i,
   input  logic                        final_i,
   input  logic [channel_num*bits-1:0] pix_i,
   input  logic [channel_num*bits-1:0] wgt_i,
   output logic [bits-1:0]             result_o
);

   logic signed [bits-1:0]     pix_s;
   logic signed [bits-1:0]     wgt_s;
   logic signed [2*bits-1:0]   prod;
   logic signed [acc_bits-1:0] beat_sum;
   logic signed [acc_bits-1:0] acc_sum;
   logic signed [acc_bits-1:0] shifted;
   logic signed [acc_bits-1:0] lim_hi;
   logic signed [acc_bits-1:0] lim_lo;
   logic signed [acc_bits-1:0] acc_d, acc_q;
   logic [bits-1:0]            res_d, res_q;

   always_comb begin
      beat_sum = '0;
      pix_s    = '0;
      wgt_s    = '0;
      prod     = '0;
      for (int c = 0; c < int'(channel_num); c++) begin
         pix_s    = signed'(pix_i[c*bits +: bits]);
         wgt_s    = signed'(wgt_i[c*bits +: bits]);
         prod     = pix_s * wgt_s;
         beat_sum = beat_sum + acc_bits'(prod);
      end
   end

   always_comb begin
      acc_sum = acc_q + beat_sum;
      acc_d   = acc_q;
      if (load_i) begin
         acc_d = beat_sum;
      end else if (acc_en_i) begin
         acc_d = acc_sum;
      end
   end

   // Arithmetic shift floors toward -inf before clamping into the pixel range.
   always_comb begin
      shifted = acc_sum >>> frac_bits;
      lim_hi  = acc_bits'(SatMax);
      lim_lo  = acc_bits'(SatMin);
      res_d   = res_q;
      if (final_i) begin
         if (relu_en && shifted[acc_bits-1]) begin
            res_d = '0;
         end else if (shifted > lim_hi) begin
            res_d = bits'(SatMax);
         end else if (shifted < lim_lo) begin
            res_d = bits'(SatMin);
         end else begin
            res_d = shifted[bits-1:0];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         res_q <= '0;
      end else begin
         acc_q <= acc_d;
         res_q <= res_d;
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/conv3_window_mac.sv
// Windowed tap-stream consumer: sequences weight_num beats per window into out_num
// parallel MAC lanes and strobes one saturated pixel per filter at window end.
module conv3_window_mac
   import conv3_window_mac_pkg::*;
#(
   parameter int unsigned bits            = QBits,
   parameter int unsigned bits_shift      = 4,
   parameter int unsigned channel_num     = 8,
   parameter int unsigned out_num         = 16,
   parameter int unsigned conv_num_seriel = 128,
   parameter int unsigned weight_num      = 25,
   parameter int unsigned weight_num_2    = 5,
   parameter int unsigned frac_bits       = QFracBits,
   parameter int unsigned acc_bits        = 40,
   parameter bit          relu_en         = 1'b1
) (
   input  logic                                  clk_in,
   input  logic                                  rst_n,
   input  logic                                  ready,
   input  logic [(channel_num<<bits_shift)-1:0]     data_in,
   input  logic [(conv_num_seriel<<bits_shift)-1:0] weight,
   output logic [(out_num<<bits_shift)-1:0]         result,
   output logic                                  result_valid,
   output logic                                  busy,
   output logic                                  proto_err
);

   localparam logic [weight_num_2-1:0] LastTap = weight_num_2'(weight_num - 1);

   win_state_e              state_d, state_q;
   logic [weight_num_2-1:0] tap_cnt_d, tap_cnt_q;
   logic                    valid_d, valid_q;
   logic                    perr_d, perr_q;
   logic                    lane_load;
   logic                    lane_acc;
   logic                    lane_final;

   always_comb begin
      state_d    = state_q;
      tap_cnt_d  = tap_cnt_q;
      valid_d    = 1'b0;
      perr_d     = perr_q;
      lane_load  = 1'b0;
      lane_acc   = 1'b0;
      lane_final = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ready) begin
               lane_load = 1'b1;
               tap_cnt_d = weight_num_2'(1);
               state_d   = StAcc;
            end
         end
         StAcc: begin
            lane_acc = 1'b1;
            // A strobe mid-window does not restart counting; it is only flagged.
            if (ready) begin
               perr_d = 1'b1;
            end
            if (tap_cnt_q == LastTap) begin
               lane_final = 1'b1;
               valid_d    = 1'b1;
               tap_cnt_d  = '0;
               state_d    = StIdle;
            end else begin
               tap_cnt_d = tap_cnt_q + weight_num_2'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         tap_cnt_q <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tap_cnt_q <= tap_cnt_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
      end
   end

   assign result_valid = valid_q;
   assign busy         = (state_q == StAcc);
   assign proto_err    = perr_q;

   for (genvar o = 0; o < int'(out_num); o++) begin : g_lane
      logic [channel_num*bits-1:0] lane_wgt;

      for (genvar c = 0; c < int'(channel_num); c++) begin : g_wsel
         assign lane_wgt[c*bits +: bits] =
            weight[weight_idx(o, c, channel_num)*bits +: bits];
      end

      conv3_mac_lane #(
         .bits        (bits),
         .channel_num (channel_num),
         .frac_bits   (frac_bits),
         .acc_bits    (acc_bits),
         .relu_en     (relu_en)
      ) u_lane (
         .clk_in   (clk_in),
         .rst_n    (rst_n),
         .load_i   (lane_load),
         .acc_en_i (lane_acc),
         .final_i  (lane_final),
         .pix_i    (data_in[channel_num*bits-1:0]),
         .wgt_i    (lane_wgt),
         .result_o (result[o*bits +: bits])
      );
   end

endmodule

// File: tb/tb_conv3_window_mac.sv
// Directed bench for conv3_window_mac: one ReLU and one linear instance share stimulus.
module tb_conv3_window_mac;

   logic           clk_in = 1'b0;
   logic           rst_n;
   logic           ready;
   logic [127:0]   data_in;
   logic [2047:0]  weight;
   logic [255:0]   res_lin, res_relu;
   logic           rv_lin, rv_relu;
   logic           busy_lin, busy_relu;
   logic           pe_lin, pe_relu;

   always #5 clk_in = ~clk_in;

   conv3_window_mac #(.relu_en(1'b0)) dut_lin (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .ready        (ready),
      .data_in      (data_in),
      .weight       (weight),
      .result       (res_lin),
      .result_valid (rv_lin),
      .busy         (busy_lin),
      .proto_err    (pe_lin)
   );

   conv3_window_mac #(.relu_en(1'b1)) dut_relu (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .ready        (ready),
      .data_in      (data_in),
      .weight       (weight),
      .result       (res_relu),
      .result_valid (rv_relu),
      .busy         (busy_relu),
      .proto_err    (pe_relu)
   );

   typedef struct {
      string       name;
      logic [15:0] pv;
      logic [15:0] wv;
      logic [15:0] exp_lin;
      logic [15:0] exp_relu;
   } vec_t;

   vec_t         tbl[6];
   int           nchk  = 0;
   int           npass = 0;
   int           cyc   = 0;
   int           vq[$];
   logic [255:0] cap_lin  = '0;
   logic [255:0] cap_relu = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nchk++;
      if (act === exp) begin
         npass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outputs are registered, so the falling edge sees this cycle's settled values.
   task automatic tick();
      @(negedge clk_in);
      cyc++;
      if (rv_lin) begin
         vq.push_back(cyc);
         cap_lin = res_lin;
      end
      if (rv_relu) cap_relu = res_relu;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         ready   = 1'b0;
         data_in = '0;
         weight  = '0;
      end
   endtask

   // kind 0: uniform pixels/weights; kind 1: single tap (ch3 at tap 12, word o=5,c=3).
   task automatic window(input int kind, input logic [15:0] pv, input logic [15:0] wv,
                         input int extra_tap, input int rst_tap, input int len,
                         output int t0);
      t0 = 0;
      for (int k = 0; k < len; k++) begin
         tick();
         if (k == 0) t0 = cyc;
         if (k == 5) chk("busy_mid", {busy_lin, busy_relu}, 2'b11);
         if (rst_tap >= 0) begin
            if (k == rst_tap) rst_n = 1'b0;
            if (k == rst_tap + 1) begin
               chk("rst_result", res_lin | res_relu, '0);
               chk("rst_flags", {rv_lin, busy_lin, pe_lin, rv_relu, busy_relu}, '0);
            end
            if (k == rst_tap + 2) rst_n = 1'b1;
         end else if (extra_tap >= 0) begin
            if (k == extra_tap) chk("perr_before", pe_lin, 1'b0);
            if (k == extra_tap + 1) chk("perr_after", {pe_lin, pe_relu}, 2'b11);
         end
         ready = (k == 0) || (k == extra_tap);
         if (kind == 0) begin
            data_in = {8{pv}};
            weight  = {128{wv}};
         end else begin
            data_in = '0;
            weight  = '0;
            if (k == 12) data_in[3*16 +: 16] = 16'h0200;
            weight[43*16 +: 16] = 16'hFF00;
         end
      end
   endtask

   initial begin
      int           t0, t1;
      logic [255:0] exp_v;

      tbl[0] = '{"identity", 16'h0100, 16'h0100, 16'h7FFF, 16'h7FFF};
      tbl[1] = '{"sat_low",  16'h7FFF, 16'h8000, 16'h8000, 16'h0000};
      tbl[2] = '{"half",     16'h0100, 16'h0080, 16'h6400, 16'h6400};
      tbl[3] = '{"neg",      16'h0100, 16'hFFF0, 16'hF380, 16'h0000};
      tbl[4] = '{"floor",    16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000};
      tbl[5] = '{"zero",     16'h0000, 16'h0000, 16'h0000, 16'h0000};

      rst_n   = 1'b0;
      ready   = 1'b0;
      data_in = '0;
      weight  = '0;
      idle(2);
      chk("reset_result", res_lin | res_relu, '0);
      chk("reset_flags", {rv_lin, busy_lin, pe_lin, rv_relu, busy_relu, pe_relu}, '0);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 6; i++) begin
         vq.delete();
         window(0, tbl[i].pv, tbl[i].wv, -1, -1, 25, t0);
         idle(3);
         chk({tbl[i].name, "_npulse"}, vq.size(), 1);
         chk({tbl[i].name, "_latency"}, (vq.size() > 0) ? vq[0] - t0 : -1, 25);
         chk({tbl[i].name, "_lin"}, cap_lin, {16{tbl[i].exp_lin}});
         chk({tbl[i].name, "_relu"}, cap_relu, {16{tbl[i].exp_relu}});
         chk({tbl[i].name, "_hold"}, res_lin, {16{tbl[i].exp_lin}});
         chk({tbl[i].name, "_idle"}, {busy_lin, rv_lin}, 2'b00);
      end

      vq.delete();
      window(1, 16'h0000, 16'h0000, -1, -1, 25, t0);
      idle(3);
      exp_v = '0;
      exp_v[5*16 +: 16] = 16'hFE00;
      chk("single_npulse", vq.size(), 1);
      chk("single_lin", cap_lin, exp_v);
      chk("single_relu", cap_relu, '0);

      vq.delete();
      window(0, 16'h0100, 16'h0100, -1, -1, 25, t0);
      window(0, 16'h0000, 16'h0000, -1, -1, 25, t1);
      idle(3);
      chk("b2b_npulse", vq.size(), 2);
      chk("b2b_first", (vq.size() > 0) ? vq[0] - t0 : -1, 25);
      chk("b2b_second", (vq.size() > 1) ? vq[1] - t0 : -1, 50);
      chk("b2b_result", cap_lin, '0);
      chk("b2b_perr", pe_lin, 1'b0);

      vq.delete();
      window(0, 16'h0100, 16'h0080, 10, -1, 25, t0);
      idle(30);
      chk("perr_npulse", vq.size(), 1);
      chk("perr_latency", (vq.size() > 0) ? vq[0] - t0 : -1, 25);
      chk("perr_result", cap_lin, {16{16'h6400}});
      chk("perr_sticky", {pe_lin, pe_relu}, 2'b11);

      vq.delete();
      window(0, 16'h0100, 16'h0100, 20, 12, 45, t0);
      idle(3);
      chk("rst_npulse", vq.size(), 1);
      chk("rst_latency", (vq.size() > 0) ? vq[0] - t0 : -1, 45);
      chk("rst_new_result", cap_lin, {16{16'h7FFF}});
      chk("rst_perr_clear", pe_lin, 1'b0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
